hvac_sequencer: RTL and testbench



---
 rtl/hvac_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_hvac_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hvac_sequencer.sv
// hvac_sequencer: heater / air-conditioner sequencer driven by sampled 8-bit
// Celsius readings. It applies hysteresis around fixed thresholds, a minimum
// run time, and a mandatory off-time (LOCKOUT) between any two activations.
// heater_on and ac_on are mutually exclusive by construction, because each is
// decoded from a single state value.
//
// Optional feature: define HVAC_SENSOR_WDT_EN to add a sensor watchdog.
// If no sample_valid arrives for WDT_CYC cycles, the sequencer enters FAULT.
// Without the macro, FAULT is unreachable and fault is tied to 0.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   temperature  unsigned Celsius reading, qualified by sample_valid
//   sample_valid one-cycle strobe qualifying temperature
//   enable       master enable; 0 forces actuators off (through LOCKOUT)
//   heater_on    registered heater drive
//   ac_on        registered AC drive
//   lockout      registered, high while in LOCKOUT
//   state_o      encoded state: IDLE=0 HEAT=1 COOL=2 LOCKOUT=3 FAULT=4
//   fault        registered sensor watchdog fault
module hvac_sequencer #(
   parameter int unsigned LOW_TH  = 20,
   parameter int unsigned HIGH_TH = 25,
   parameter int unsigned HYST    = 1,
   parameter int unsigned MIN_RUN = 1000,
   parameter int unsigned MIN_OFF = 500,
   parameter int unsigned CNT_W   = 16
`ifdef HVAC_SENSOR_WDT_EN
   ,
   parameter int unsigned WDT_CYC = 10000
`endif
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] temperature,
   input  logic       sample_valid,
   input  logic       enable,
   output logic       heater_on,
   output logic       ac_on,
   output logic       lockout,
   output logic [2:0] state_o,
   output logic       fault
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAT    = 3'd1,
      ST_COOL    = 3'd2,
      ST_LOCKOUT = 3'd3,
      ST_FAULT   = 3'd4
   } state_t;

   // Thresholds are compared in 9 bits so LOW_TH+HYST cannot wrap
   localparam logic [8:0] LOW9      = 9'(LOW_TH);
   localparam logic [8:0] HIGH9     = 9'(HIGH_TH);
   localparam logic [8:0] HEAT_STOP = 9'(LOW_TH + HYST);
   localparam logic [8:0] COOL_STOP = 9'(HIGH_TH - HYST);

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] RUN_MAX  = CNT_W'(MIN_RUN);
   // MIN_OFF=0 behaves like 1: the load value is 0, giving a single LOCKOUT cycle
   localparam logic [CNT_W-1:0] OFF_LOAD = (MIN_OFF == 0) ? '0 : CNT_W'(MIN_OFF - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] run_cnt;
   logic [CNT_W-1:0] off_cnt;
   logic [8:0]       temp9;
   logic             run_done;
   logic             heater_d;
   logic             ac_d;
   logic             lockout_d;
   logic             fault_d;
   logic             fault_q;

   assign temp9    = {1'b0, temperature};
   assign run_done = (run_cnt == RUN_MAX);
   assign state_o  = state;

`ifdef HVAC_SENSOR_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYC + 1);
   localparam logic [WDT_W-1:0] WDT_ONE = WDT_W'(1);
   localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(WDT_CYC);

   logic [WDT_W-1:0] wdt_cnt;
   logic             wdt_expired;

   assign wdt_expired = (wdt_cnt == WDT_MAX);

   // Cycles since the last strobe, saturating at the timeout
   always_ff @(posedge clk or negedge rst_n) begin : p_wdt
      if (!rst_n) begin
         wdt_cnt <= '0;
      end else if (sample_valid) begin
         wdt_cnt <= '0;
      end else if (!wdt_expired) begin
         wdt_cnt <= wdt_cnt + WDT_ONE;
      end
   end

   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin : p_state
      if (!rst_n) begin
         state     <= ST_IDLE;
         heater_on <= 1'b0;
         ac_on     <= 1'b0;
         lockout   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state     <= state_next;
         heater_on <= heater_d;
         ac_on     <= ac_d;
         lockout   <= lockout_d;
         fault_q   <= fault_d;
      end
   end

   // Run-time counter (cleared on entry to HEAT/COOL) and off-time counter
   // (loaded on entry to LOCKOUT)
   always_ff @(posedge clk or negedge rst_n) begin : p_cnt
      if (!rst_n) begin
         run_cnt <= '0;
         off_cnt <= '0;
      end else begin
         if ((state_next == ST_HEAT || state_next == ST_COOL) && state_next != state) begin
            run_cnt <= '0;
         end else if ((state == ST_HEAT || state == ST_COOL) && !run_done) begin
            run_cnt <= run_cnt + CNT_ONE;
         end

         if (state_next == ST_LOCKOUT && state != ST_LOCKOUT) begin
            off_cnt <= OFF_LOAD;
         end else if (state == ST_LOCKOUT && off_cnt != '0) begin
            off_cnt <= off_cnt - CNT_ONE;
         end
      end
   end

   // Next-state decode; enable=0 outranks a concurrent sample
   always_comb begin : p_next
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (enable && sample_valid) begin
               if (temp9 < LOW9) begin
                  state_next = ST_HEAT;
               end else if (temp9 > HIGH9) begin
                  state_next = ST_COOL;
               end
            end
         end
         ST_HEAT: begin
            if (!enable) begin
               state_next = ST_LOCKOUT;
            end else if (sample_valid && temp9 >= HEAT_STOP && run_done) begin
               state_next = ST_LOCKOUT;
            end
         end
         ST_COOL: begin
            if (!enable) begin
               state_next = ST_LOCKOUT;
            end else if (sample_valid && temp9 <= COOL_STOP && run_done) begin
               state_next = ST_LOCKOUT;
            end
         end
         ST_LOCKOUT: begin
            if (off_cnt == '0) begin
               state_next = ST_IDLE;
            end
         end
`ifdef HVAC_SENSOR_WDT_EN
         ST_FAULT: begin
            if (sample_valid && enable) begin
               state_next = ST_LOCKOUT;
            end
         end
`endif
         default: state_next = ST_IDLE;
      endcase
`ifdef HVAC_SENSOR_WDT_EN
      // A silent sensor overrides every other transition
      if (wdt_expired && state != ST_FAULT) begin
         state_next = ST_FAULT;
      end
`endif
   end

   // Output decode from the next state, so outputs change with the state register
   always_comb begin : p_out
      heater_d  = 1'b0;
      ac_d      = 1'b0;
      lockout_d = 1'b0;
      fault_d   = 1'b0;
      case (state_next)
         ST_HEAT:    heater_d  = 1'b1;
         ST_COOL:    ac_d      = 1'b1;
         ST_LOCKOUT: lockout_d = 1'b1;
         ST_FAULT:   fault_d   = 1'b1;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_hvac_sequencer.sv
// Scoreboard bench for hvac_sequencer. The bench uses MIN_RUN=4 and MIN_OFF=3.
// With HVAC_SENSOR_WDT_EN defined, it also sets WDT_CYC=8.
// A reference model predicts the outputs after each edge. Those predictions
// are queued when the stimulus is driven and compared after the edge.
module tb_hvac_sequencer;

   localparam int LOW     = 20;
   localparam int HIGH    = 25;
   localparam int HYS     = 1;
   localparam int RUN     = 4;
   localparam int OFF     = 3;
   localparam int WDT     = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] temperature;
   logic       sample_valid;
   logic       enable;
   logic       heater_on;
   logic       ac_on;
   logic       lockout;
   logic [2:0] state_o;
   logic       fault;

   always #5 clk = ~clk;

   hvac_sequencer #(
      .LOW_TH (LOW),
      .HIGH_TH(HIGH),
      .HYST   (HYS),
      .MIN_RUN(RUN),
      .MIN_OFF(OFF),
      .CNT_W  (16)
`ifdef HVAC_SENSOR_WDT_EN
      ,
      .WDT_CYC(WDT)
`endif
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .temperature (temperature),
      .sample_valid(sample_valid),
      .enable      (enable),
      .heater_on   (heater_on),
      .ac_on       (ac_on),
      .lockout     (lockout),
      .state_o     (state_o),
      .fault       (fault)
   );

   typedef struct {
      int st;
      int h;
      int a;
      int l;
      int f;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   int m_state;
   int m_run;
   int m_lk;
   int m_wdt;

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got=%0d expected=%0d", tag, $time, got, exp);
      end
   endtask

   task automatic mdl_reset();
      m_state = 0;
      m_run   = 0;
      m_lk    = 0;
      m_wdt   = 0;
      q.delete();
   endtask

   // Predicts the state after the coming edge and queues it
   task automatic mdl_step(input logic sv, input int t, input logic en);
      int   ns;
      exp_t e;
      ns = m_state;
      case (m_state)
         0: if (en && sv) begin
               if (t < LOW) ns = 1;
               else if (t > HIGH) ns = 2;
            end
         1: if (!en || (sv && t >= LOW + HYS && m_run >= RUN)) ns = 3;
         2: if (!en || (sv && t <= HIGH - HYS && m_run >= RUN)) ns = 3;
         3: if (m_lk >= ((OFF == 0) ? 1 : OFF)) ns = 0;
         4: if (sv && en) ns = 3;
         default: ns = 0;
      endcase
`ifdef HVAC_SENSOR_WDT_EN
      if (m_state != 4 && m_wdt >= WDT) ns = 4;
      m_wdt = sv ? 0 : m_wdt + 1;
`endif
      if (ns == 3) m_lk = (m_state == 3) ? m_lk + 1 : 1;
      if (ns == 1 || ns == 2) m_run = (ns == m_state) ? m_run + 1 : 0;
      m_state = ns;
      e.st = ns;
      e.h  = (ns == 1) ? 1 : 0;
      e.a  = (ns == 2) ? 1 : 0;
      e.l  = (ns == 3) ? 1 : 0;
      e.f  = (ns == 4) ? 1 : 0;
      q.push_back(e);
   endtask

   // One clock: drive inputs, predict, wait for the edge, compare
   task automatic cyc(input logic sv, input int t, input logic en);
      exp_t e;
      sample_valid = sv;
      temperature  = 8'(t);
      enable       = en;
      mdl_step(sv, t, en);
      @(posedge clk);
      #1;
      if (q.size() == 0) begin
         check("queue_empty", 1, 0);
      end else begin
         e = q.pop_front();
         check("state",   int'(state_o),   e.st);
         check("heater",  int'(heater_on), e.h);
         check("ac",      int'(ac_on),     e.a);
         check("lockout", int'(lockout),   e.l);
         check("fault",   int'(fault),     e.f);
      end
      check("exclusive", int'(heater_on & ac_on), 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1);
   endtask

   initial begin
      rst_n        = 1'b0;
      temperature  = 8'd0;
      sample_valid = 1'b0;
      enable       = 1'b0;
      mdl_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_state",  int'(state_o),   0);
      check("rst_heater", int'(heater_on), 0);
      check("rst_ac",     int'(ac_on),     0);
      check("rst_lock",   int'(lockout),   0);
      check("rst_fault",  int'(fault),     0);
      @(negedge clk);
      rst_n = 1'b1;

      // Heat entry, hysteresis, minimum run, then lockout of exactly MIN_OFF
      cyc(1'b1, 18, 1'b1);
      check("heat_entry", int'(state_o), 1);
      cyc(1'b1, 20, 1'b1);
      check("heat_hyst", int'(heater_on), 1);
      cyc(1'b1, 21, 1'b1);
      check("heat_minrun", int'(heater_on), 1);
      idle(2);
      cyc(1'b1, 21, 1'b1);
      check("heat_exit", int'(lockout), 1);
      idle(2);
      check("lock_hold", int'(lockout), 1);
      idle(1);
      check("lock_done", int'(state_o), 0);

      // In-band samples, then cooling with hysteresis and minimum run
      cyc(1'b1, 20, 1'b1);
      cyc(1'b1, 25, 1'b1);
      check("band_idle", int'(state_o), 0);
      cyc(1'b1, 26, 1'b1);
      check("cool_entry", int'(ac_on), 1);
      cyc(1'b1, 25, 1'b1);
      idle(4);
      cyc(1'b1, 24, 1'b1);
      check("cool_exit", int'(lockout), 1);
      idle(3);

      // A hot reading while heating goes through LOCKOUT before COOL
      cyc(1'b1, 18, 1'b1);
      idle(4);
      cyc(1'b1, 30, 1'b1);
      check("heat_to_lock", int'(state_o), 3);
      idle(3);
      check("no_direct_cool", int'(ac_on), 0);
      cyc(1'b1, 30, 1'b1);
      check("cool_after_lock", int'(state_o), 2);

      // enable=0 beats a concurrent sample and ignores the minimum run
      cyc(1'b1, 30, 1'b0);
      check("disable_lock", int'(lockout), 1);
      idle(3);

      // Extreme readings, and disable while IDLE
      cyc(1'b1, 0, 1'b1);
      check("temp0_heat", int'(heater_on), 1);
      cyc(1'b0, 0, 1'b0);
      idle(3);
      cyc(1'b1, 18, 1'b0);
      check("idle_disabled", int'(state_o), 0);
      cyc(1'b1, 255, 1'b1);
      check("temp255_cool", int'(ac_on), 1);

      // Asynchronous reset while cooling
      #2;
      rst_n = 1'b0;
      sample_valid = 1'b0;
      #1;
      check("async_rst_ac",    int'(ac_on),   0);
      check("async_rst_state", int'(state_o), 0);
      mdl_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 22, 1'b1);
      check("post_rst_idle", int'(lockout), 0);

`ifdef HVAC_SENSOR_WDT_EN
      // A silent sensor while heating raises a fault; the next sample recovers
      cyc(1'b1, 18, 1'b1);
      idle(10);
      check("wdt_fault",  int'(fault),     1);
      check("wdt_heater", int'(heater_on), 0);
      cyc(1'b1, 22, 1'b1);
      check("wdt_recover_lock",  int'(lockout), 1);
      check("wdt_recover_fault", int'(fault),   0);
      idle(3);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
